// File: rtl/eth_fcs_check.sv
// Receive-side Ethernet FCS checker: CRC-32 residue check and FCS stripping
// through a 4-byte delay line, with per-frame status reporting.
module eth_fcs_check #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    input  logic             rx_sof,
    input  logic             rx_eof,
    output logic [7:0]       out_data,
    output logic             out_valid,
    output logic             out_eof,
    output logic             frame_done,
    output logic             frame_ok,
    output logic             fcs_err,
    output logic             runt,
    output logic             abort,
    output logic [LEN_W-1:0] frame_len
);

    typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;

    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
    localparam logic [31:0] RESIDUE  = 32'hDEBB_20E3;

    function automatic logic [31:0] crc_byte(input logic [31:0] c,
                                             input logic [7:0]  d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    state_t            state_q, state_d;
    logic [1:0]        held_q, held_d;
    logic [31:0]       dl_q, dl_d;
    logic [31:0]       crc_q, crc_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [7:0]        odata_q, odata_d;
    logic              ovalid_q, ovalid_d;
    logic              oeof_q, oeof_d;
    logic              done_q, done_d;
    logic              ok_q, ok_d;
    logic              err_q, err_d;
    logic              runt_q, runt_d;
    logic              abort_q, abort_d;
    logic [LEN_W-1:0]  flen_q, flen_d;

    logic [31:0]       crc_upd;
    logic [LEN_W-1:0]  len_inc;

    assign crc_upd = crc_byte(rx_sof ? CRC_INIT : crc_q, rx_data);
    assign len_inc = (len_q == '1) ? len_q : len_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        held_d   = held_q;
        dl_d     = dl_q;
        crc_d    = crc_q;
        len_d    = len_q;
        odata_d  = odata_q;
        ovalid_d = 1'b0;
        oeof_d   = 1'b0;
        done_d   = 1'b0;
        ok_d     = 1'b0;
        err_d    = 1'b0;
        runt_d   = 1'b0;
        abort_d  = 1'b0;
        flen_d   = '0;
        if (rx_valid && rx_sof) begin
            // An in-flight frame is reported as aborted; the new byte restarts.
            if (state_q != IDLE) begin
                done_d  = 1'b1;
                abort_d = 1'b1;
                flen_d  = len_q;
            end else if (rx_eof) begin
                done_d = 1'b1;
                runt_d = 1'b1;
            end
            crc_d   = crc_upd;
            len_d   = '0;
            dl_d    = {24'h0, rx_data};
            held_d  = 2'd1;
            state_d = rx_eof ? IDLE : FILL;
        end else if (rx_valid && state_q != IDLE) begin
            crc_d = crc_upd;
            dl_d  = {dl_q[23:0], rx_data};
            if (state_q == STREAM) begin
                ovalid_d = 1'b1;
                odata_d  = dl_q[31:24];
                len_d    = len_inc;
            end
            if (rx_eof) begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (state_q == STREAM) begin
                    oeof_d = 1'b1;
                    flen_d = len_inc;
                    ok_d   = (crc_upd == RESIDUE);
                    err_d  = (crc_upd != RESIDUE);
                end else begin
                    runt_d = 1'b1;
                end
            end else if (state_q == FILL) begin
                held_d = held_q + 2'd1;
                if (held_q == 2'd3)
                    state_d = STREAM;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            held_q   <= '0;
            dl_q     <= '0;
            crc_q    <= CRC_INIT;
            len_q    <= '0;
            odata_q  <= '0;
            ovalid_q <= 1'b0;
            oeof_q   <= 1'b0;
            done_q   <= 1'b0;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
            runt_q   <= 1'b0;
            abort_q  <= 1'b0;
            flen_q   <= '0;
        end else begin
            state_q  <= state_d;
            held_q   <= held_d;
            dl_q     <= dl_d;
            crc_q    <= crc_d;
            len_q    <= len_d;
            odata_q  <= odata_d;
            ovalid_q <= ovalid_d;
            oeof_q   <= oeof_d;
            done_q   <= done_d;
            ok_q     <= ok_d;
            err_q    <= err_d;
            runt_q   <= runt_d;
            abort_q  <= abort_d;
            flen_q   <= flen_d;
        end
    end

    assign out_data   = odata_q;
    assign out_valid  = ovalid_q;
    assign out_eof    = oeof_q;
    assign frame_done = done_q;
    assign frame_ok   = ok_q;
    assign fcs_err    = err_q;
    assign runt       = runt_q;
    assign abort      = abort_q;
    assign frame_len  = flen_q;

endmodule

// File: tb/tb_eth_fcs_check.sv
// Directed bench for eth_fcs_check: good/bad FCS, runts, abort, gaps and
// mid-frame reset, with hand-computed expected payloads and status words.
module tb_eth_fcs_check;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_sof;
    logic        rx_eof;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_eof;
    logic        frame_done;
    logic        frame_ok;
    logic        fcs_err;
    logic        runt;
    logic        abort;
    logic [15:0] frame_len;

    int checks   = 0;
    int failures = 0;

    // status word: {ok, err, runt, abort, len}
    logic [8:0]  out_q[$];
    logic [19:0] st_q[$];
    logic [7:0]  good[13];

    localparam logic [19:0] ST_OK9  = {4'b1000, 16'd9};
    localparam logic [19:0] ST_ERR9 = {4'b0100, 16'd9};
    localparam logic [19:0] ST_RUNT = {4'b0010, 16'd0};
    localparam logic [19:0] ST_ABT2 = {4'b0001, 16'd2};

    eth_fcs_check #(.LEN_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_sof     (rx_sof),
        .rx_eof     (rx_eof),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_eof    (out_eof),
        .frame_done (frame_done),
        .frame_ok   (frame_ok),
        .fcs_err    (fcs_err),
        .runt       (runt),
        .abort      (abort),
        .frame_len  (frame_len)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (out_valid)
            out_q.push_back({out_eof, out_data});
        if (frame_done) begin
            st_q.push_back({frame_ok, fcs_err, runt, abort, frame_len});
            checks++;
            if ($countones({frame_ok, fcs_err, runt, abort}) != 1) begin
                failures++;
                $display("FAIL onehot_status flags=%b required exactly one",
                         {frame_ok, fcs_err, runt, abort});
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic s, input logic e);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = d;
        rx_sof   = s;
        rx_eof   = e;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_valid = 1'b0;
            rx_sof   = 1'b0;
            rx_eof   = 1'b0;
            rx_data  = 8'h00;
        end
    endtask

    task automatic send_frame(input logic [7:0] last, input bit gaps);
        for (int i = 0; i < 13; i++) begin
            send((i == 12) ? last : good[i], i == 0, i == 12);
            if (gaps)
                idle(1);
        end
    endtask

    task automatic clear_q();
        out_q.delete();
        st_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(3);
        checks++;
        if ({out_data, out_valid, out_eof, frame_done} !== 11'h0) begin
            failures++;
            $display("FAIL reset_out got=%h want=0",
                     {out_data, out_valid, out_eof, frame_done});
        end
        checks++;
        if ({frame_ok, fcs_err, runt, abort, frame_len} !== 20'h0) begin
            failures++;
            $display("FAIL reset_status got=%h want=0",
                     {frame_ok, fcs_err, runt, abort, frame_len});
        end
        reset = 1'b0;
        idle(2);
        checks++;
        if ({out_valid, frame_done} !== 2'b00) begin
            failures++;
            $display("FAIL reset_quiet got=%b want=00", {out_valid, frame_done});
        end
    endtask

    task automatic test_good();
        clear_q();
        send_frame(8'hCB, 1'b0);
        idle(3);
        checks++;
        if (out_q.size() != 9) begin
            failures++;
            $display("FAIL good_count got=%0d want=9", out_q.size());
        end
        for (int i = 0; i < 9 && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== {i == 8, 8'h31 + 8'(i)}) begin
                failures++;
                $display("FAIL good_byte%0d got=%h want=%h", i, out_q[i],
                         {i == 8, 8'h31 + 8'(i)});
            end
        end
        checks++;
        if (st_q.size() != 1 || st_q[0] !== ST_OK9) begin
            failures++;
            $display("FAIL good_status n=%0d got=%h want=%h", st_q.size(),
                     (st_q.size() > 0) ? st_q[0] : 20'h0, ST_OK9);
        end
    endtask

    task automatic test_bad_fcs();
        clear_q();
        send_frame(8'hCA, 1'b0);
        idle(3);
        checks++;
        if (out_q.size() != 9 || out_q[8] !== 9'h139) begin
            failures++;
            $display("FAIL bad_payload n=%0d want=9 last=139", out_q.size());
        end
        checks++;
        if (st_q.size() != 1 || st_q[0] !== ST_ERR9) begin
            failures++;
            $display("FAIL bad_status n=%0d got=%h want=%h", st_q.size(),
                     (st_q.size() > 0) ? st_q[0] : 20'h0, ST_ERR9);
        end
    endtask

    task automatic test_runt();
        clear_q();
        send(8'h0A, 1'b1, 1'b0);
        send(8'h0C, 1'b0, 1'b0);
        send(8'h0E, 1'b0, 1'b1);
        send(8'h77, 1'b1, 1'b1);
        idle(3);
        checks++;
        if (out_q.size() != 0) begin
            failures++;
            $display("FAIL runt_out got=%0d want=0", out_q.size());
        end
        checks++;
        if (st_q.size() != 2) begin
            failures++;
            $display("FAIL runt_count got=%0d want=2", st_q.size());
        end
        for (int i = 0; i < st_q.size(); i++) begin
            checks++;
            if (st_q[i] !== ST_RUNT) begin
                failures++;
                $display("FAIL runt_status%0d got=%h want=%h", i, st_q[i],
                         ST_RUNT);
            end
        end
    endtask

    task automatic test_abort();
        clear_q();
        for (int i = 0; i < 6; i++)
            send(8'hA0 + 8'(i), i == 0, 1'b0);
        send_frame(8'hCB, 1'b0);
        idle(3);
        checks++;
        if (out_q.size() != 11) begin
            failures++;
            $display("FAIL abort_count got=%0d want=11", out_q.size());
        end
        checks++;
        if (out_q.size() > 1 && {out_q[0], out_q[1]} !== {9'h0A0, 9'h0A1}) begin
            failures++;
            $display("FAIL abort_bytes got=%h %h want=0a0 0a1",
                     out_q[0], out_q[1]);
        end
        checks++;
        if (out_q.size() == 11 && out_q[10] !== 9'h139) begin
            failures++;
            $display("FAIL abort_b_last got=%h want=139", out_q[10]);
        end
        checks++;
        if (st_q.size() != 2 || {st_q[0], st_q[1]} !== {ST_ABT2, ST_OK9}) begin
            failures++;
            $display("FAIL abort_status n=%0d want=%h,%h", st_q.size(),
                     ST_ABT2, ST_OK9);
        end
    endtask

    task automatic test_gaps();
        clear_q();
        send(8'h55, 1'b0, 1'b0);
        send(8'h66, 1'b0, 1'b1);
        idle(2);
        send_frame(8'hCB, 1'b1);
        idle(3);
        checks++;
        if (out_q.size() != 9) begin
            failures++;
            $display("FAIL gaps_count got=%0d want=9", out_q.size());
        end
        for (int i = 0; i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== {i == 8, 8'h31 + 8'(i)}) begin
                failures++;
                $display("FAIL gaps_byte%0d got=%h want=%h", i, out_q[i],
                         {i == 8, 8'h31 + 8'(i)});
            end
        end
        checks++;
        if (st_q.size() != 1 || st_q[0] !== ST_OK9) begin
            failures++;
            $display("FAIL gaps_status n=%0d want=%h", st_q.size(), ST_OK9);
        end
    endtask

    task automatic test_back_to_back();
        clear_q();
        send_frame(8'hCB, 1'b0);
        send_frame(8'hCA, 1'b0);
        idle(3);
        checks++;
        if (out_q.size() != 18) begin
            failures++;
            $display("FAIL b2b_count got=%0d want=18", out_q.size());
        end
        checks++;
        if (out_q.size() == 18 && {out_q[8], out_q[9], out_q[17]}
                !== {9'h139, 9'h031, 9'h139}) begin
            failures++;
            $display("FAIL b2b_edges got=%h %h %h want=139 031 139",
                     out_q[8], out_q[9], out_q[17]);
        end
        checks++;
        if (st_q.size() != 2 || {st_q[0], st_q[1]} !== {ST_OK9, ST_ERR9}) begin
            failures++;
            $display("FAIL b2b_status n=%0d want=%h,%h", st_q.size(),
                     ST_OK9, ST_ERR9);
        end
    endtask

    task automatic test_mid_reset();
        clear_q();
        for (int i = 0; i < 7; i++)
            send(good[i], i == 0, 1'b0);
        @(negedge clk);
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_sof   = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_data, out_valid, out_eof, frame_done, frame_ok, fcs_err,
             runt, abort, frame_len} !== 31'h0) begin
            failures++;
            $display("FAIL midrst_outputs got=%h want=0",
                     {out_data, out_valid, out_eof, frame_done, frame_ok,
                      fcs_err, runt, abort, frame_len});
        end
        checks++;
        if (out_q.size() != 3 || out_q[2] !== 9'h033) begin
            failures++;
            $display("FAIL midrst_fwd n=%0d want=3 last=033", out_q.size());
        end
        reset = 1'b0;
        idle(2);
        send_frame(8'hCB, 1'b0);
        idle(3);
        checks++;
        if (st_q.size() != 1 || st_q[0] !== ST_OK9) begin
            failures++;
            $display("FAIL midrst_status n=%0d want=%h", st_q.size(), ST_OK9);
        end
        checks++;
        if (out_q.size() != 12) begin
            failures++;
            $display("FAIL midrst_count got=%0d want=12", out_q.size());
        end
    endtask

    initial begin
        good = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38,
                 8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB};
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_sof   = 1'b0;
        rx_eof   = 1'b0;
        rx_data  = 8'h00;
        test_reset();
        test_good();
        test_bad_fcs();
        test_runt();
        test_abort();
        test_gaps();
        test_back_to_back();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/eth_fcs_check.md
# eth_fcs_check

Receive-side frame check sequence (FCS) checker for the Ethernet datapath. It is the receive-side counterpart of the transmit-side `crc32` generator. It accepts a byte stream that carries the 4-byte FCS at the end of each frame and computes CRC-32 over the whole frame. It forwards only the payload bytes, stripping the FCS through a 4-byte delay line, and reports per-frame status: good/bad FCS, runt, abort, and payload length.

## Interface
Parameters:
- LEN_W, 16, width of `frame_len`; the length counter saturates at 2^LEN_W-1.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs.
- rx_data  in  8  received byte.
- rx_valid  in  1  `rx_data` qualifier; one byte is accepted per cycle when high.
- rx_sof  in  1  first byte of frame; meaningful only with `rx_valid`.
- rx_eof  in  1  last byte of frame (last FCS byte); meaningful only with `rx_valid`.
- out_data  out  8  forwarded payload byte.
- out_valid  out  1  `out_data` qualifier.
- out_eof  out  1  marks the last payload byte.
- frame_done  out  1  one-cycle pulse; status outputs are valid in this cycle.
- frame_ok  out  1  frame ended normally, length ≥ 5 bytes, and FCS residue is correct.
- fcs_err  out  1  length ≥ 5 bytes but residue is wrong.
- runt  out  1  frame ended with fewer than 5 bytes.
- abort  out  1  frame terminated by a new `rx_sof` before `rx_eof`.
- frame_len  out  LEN_W  payload byte count (total bytes − 4), saturating.

## Operation
- CRC convention:
  - reflected polynomial 0xEDB88320, LSB of each byte first;
  - register initialised to 0xFFFFFFFF at each accepted `rx_sof` byte;
  - each accepted byte updates the register.
- Residue check: after the `rx_eof` byte, the register must equal 0xDEBB20E3. This is the residue for data followed by the FCS as ~CRC, LSB byte first.
- States: IDLE, FILL (0–3 bytes held in the delay line), STREAM (delay line full).
  - IDLE: bytes without `rx_sof` are dropped and produce no status. `rx_sof` goes to FILL with 1 byte held.
  - FILL: each accepted byte is pushed. When the 4th byte is held, go to STREAM. Nothing is forwarded.
  - STREAM: each accepted byte pushes the delay line. The oldest byte is emitted on `out_*`.
- `rx_eof` byte, any state:
  - the frame ends and the state returns to IDLE;
  - the 4 bytes left in the delay line (the FCS) are discarded;
  - the byte emitted by that push (only in STREAM) carries `out_eof=1`.
- Runt: `rx_eof` in IDLE-with-`rx_sof` or in FILL means fewer than 5 bytes total. Result: `runt=1`, `frame_len=0`, no bytes forwarded.
- `rx_sof` and `rx_eof` on the same byte: this is a 1-byte runt.
- `rx_sof` while in FILL/STREAM:
  - the current frame is reported with `abort=1` and `frame_ok=0`;
  - the held bytes are discarded;
  - no `out_eof` is issued for the aborted frame;
  - the new byte starts a fresh frame in the same cycle.
- Status flags: exactly one of `frame_ok`, `fcs_err`, `runt`, `abort` is high in a `frame_done` cycle. All are 0 otherwise.
- Length counting: `frame_len` counts bytes emitted on `out_*` for the frame and saturates. For an abort it reports bytes already forwarded.
- Idle gaps: `rx_valid` low for any number of cycles mid-frame changes nothing.

## Timing
- All outputs are registered.
- `out_valid`/`out_data`/`out_eof` appear the cycle after the accepted input byte that pushed them out.
- `frame_done` and status appear the cycle after the `rx_eof` byte or aborting `rx_sof` byte is accepted. This is the same cycle as `out_eof` when payload exists.
- Residue evaluation uses the CRC updated with the `rx_eof` byte itself; it is combinational into the status register.
- Throughput: 1 byte/cycle, no backpressure.
- Reset values: every output 0, state IDLE, CRC 0xFFFFFFFF, `frame_len` 0, delay line cleared.
- Reset mid-frame: the frame is dropped silently with no `frame_done`. The next `rx_sof` starts cleanly.

## Test plan
- ASCII "123456789" (0x31..0x39) then FCS 0x26,0x39,0xF4,0xCB with sof/eof, back-to-back → 9 `out_valid` bytes 0x31..0x39, `out_eof` on 0x39, `frame_done` with `frame_ok=1`, `frame_len=9`.
- Same frame, last FCS byte 0xCA → identical payload out, `fcs_err=1`, `frame_ok=0`, `frame_len=9`.
- 3-byte frame 0x0A,0x0C,0x0E (eof on 0x0E); also a single byte with sof=eof=1 → no `out_valid`, `runt=1`, `frame_len=0`.
- 6 bytes of frame A, then `rx_sof` with frame B = the good frame from the first scenario → A: 2 bytes forwarded, `abort=1`, `frame_len=2`, no `out_eof`; B: `frame_ok=1`, `frame_len=9`.
- Good frame with `rx_valid` low every other cycle, plus stray bytes without sof while IDLE → strays ignored, result identical to the first scenario.
- Reset pulsed after 7 bytes of a frame → all outputs 0 the cycle after reset asserts, no `frame_done`; the following good frame passes with `frame_ok=1`.
